sim_host_mux: RTL



---
 rtl/sim_host_mux.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sim_host_mux.sv
// Simulation host device: NCH console byte FIFOs drained round-robin onto one
// character stream, plus a sticky tohost exit register, cycle counter and watchdog.
module sim_host_mux #(
    parameter int          NCH        = 2,
    parameter int          DEPTH      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
    parameter int unsigned MAX_CYCLES = 0,
    localparam int         CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          host_valid,
    input  logic          host_instr,
    input  logic [31:0]   host_addr,
    input  logic [31:0]   host_wdata,
    input  logic [3:0]    host_wstrb,
    output logic [31:0]   host_rdata,
    output logic          host_ready,
    output logic          char_valid,
    output logic [CW-1:0] char_chan,
    output logic [7:0]    char_data,
    input  logic          char_ready,
    output logic          done,
    output logic [31:0]   exit_code,
    output logic          timeout
);

    localparam int AW = $clog2(DEPTH);

    logic [NCH-1:0]       push, pop, empty, full, tx_sel;
    logic [NCH-1:0][7:0]  head;
    logic [NCH-1:0][AW:0] count;

    logic [11:0]   off;
    logic          in_win, is_wr, tx_full, sample, hs;
    logic [31:0]   rd_val, cycle;
    logic [CW-1:0] rr_ptr, sel_chan;
    logic          sel_found;
    logic [7:0]    sel_data;

    assign off    = host_addr[11:0];
    assign in_win = !host_instr && (host_addr[31:12] == BASE_ADDR[31:12]);
    assign is_wr  = |host_wstrb;

    always_comb begin
        tx_sel = '0;
        for (int c = 0; c < NCH; c++)
            tx_sel[c] = in_win && (off[11:8] == 4'h0) && (off[1:0] == 2'b00) &&
                        (int'(off[7:2]) == c);
    end

    // Stall on the registered full flag, so a same-cycle pop only frees the slot next cycle.
    assign tx_full = |(tx_sel & full);
    assign sample  = host_valid && !host_ready && !(host_wstrb[0] && tx_full);
    assign push    = tx_sel & {NCH{sample && host_wstrb[0]}};
    assign hs      = char_valid && char_ready;

    always_comb begin
        pop = '0;
        for (int c = 0; c < NCH; c++)
            pop[c] = hs && (int'(char_chan) == c);
    end

    always_comb begin
        rd_val = '0;
        if (in_win && !is_wr) begin
            for (int c = 0; c < NCH; c++)
                if (tx_sel[c])
                    rd_val = {16'b0, 8'(count[c]), 6'b0, empty[c], full[c]};
            case (off)
                12'h100: rd_val = exit_code;
                12'h104: rd_val = cycle;
                12'h108: rd_val = {29'b0, timeout, done, ~&empty};
                default: ;
            endcase
        end
    end

    // First non-empty channel at or after the round-robin pointer.
    always_comb begin : pick
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_chan  = '0;
        sel_data  = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(rr_ptr) + i) % NCH;
            if (!sel_found && !empty[idx]) begin
                sel_found = 1'b1;
                sel_chan  = CW'(idx);
                sel_data  = head[idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            host_ready <= 1'b0;
            host_rdata <= '0;
            char_valid <= 1'b0;
            char_chan  <= '0;
            char_data  <= '0;
            rr_ptr     <= '0;
            done       <= 1'b0;
            exit_code  <= '0;
            timeout    <= 1'b0;
            cycle      <= '0;
        end else begin
            host_ready <= sample;
            host_rdata <= sample ? rd_val : '0;
            if (sample && is_wr && in_win && (off == 12'h100) && !done) begin
                done      <= 1'b1;
                exit_code <= host_wdata;
            end
            if (!done && !timeout) begin
                cycle <= cycle + 32'd1;
                if ((MAX_CYCLES != 0) && (cycle == MAX_CYCLES - 1))
                    timeout <= 1'b1;
            end
            if (hs) begin
                char_valid <= 1'b0;
                rr_ptr     <= (int'(char_chan) == NCH - 1) ? '0 : char_chan + 1'b1;
            end else if (!char_valid && sel_found) begin
                char_valid <= 1'b1;
                char_chan  <= sel_chan;
                char_data  <= sel_data;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        sim_host_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push[c]),
            .pop   (pop[c]),
            .din   (host_wdata[7:0]),
            .dout  (head[c]),
            .count (count[c]),
            .empty (empty[c]),
            .full  (full[c])
        );
    end

endmodule

// Per-channel byte FIFO; pointers wrap modulo DEPTH, count is one bit wider.
module sim_host_fifo #(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic [AW:0] count,
    output logic        empty,
    output logic        full
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= din;

endmodule
